// File: rtl/branch_cmp_arbiter.sv
// Round-robin arbiter that shares one branch comparator between branch resolution
// (requester 0) and the ALU set-less-than path (requester 1).
module branch_cmp_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [2:0]      req0_funct3,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [2:0]      req1_funct3,
  output logic [XLEN-1:0] cmp_operand1,
  output logic [XLEN-1:0] cmp_operand2,
  output logic            cmp_BrUn,
  input  logic            cmp_BrEq,
  input  logic            cmp_BrLT,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic            rsp_result,
  output logic            rsp_illegal
);

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              owner_q, owner_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              result_q, result_d;
  logic              illegal_q, illegal_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;

  logic grant0, grant1;
  logic dec_result, dec_illegal;

  // Ready is combinational but suppressed while reset is asserted.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || !rr_ptr_q);
    grant1     = req1_valid && (!req0_valid ||  rr_ptr_q);
    req0_ready = rst_n && (state_q == IDLE) && grant0;
    req1_ready = rst_n && (state_q == IDLE) && grant1;
  end

  always_comb begin
    dec_result  = 1'b0;
    dec_illegal = 1'b0;
    case (funct3_q)
      3'b000:         dec_result  = cmp_BrEq;
      3'b001:         dec_result  = ~cmp_BrEq;
      3'b100, 3'b110: dec_result  = cmp_BrLT;
      3'b101, 3'b111: dec_result  = ~cmp_BrLT;
      default:        dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    a_d       = a_q;
    b_d       = b_q;
    funct3_d  = funct3_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (req0_ready) begin
          a_d      = req0_a;
          b_d      = req0_b;
          funct3_d = req0_funct3;
          owner_d  = 1'b0;
          rr_ptr_d = 1'b1;
          state_d  = CMP;
        end else if (req1_ready) begin
          a_d      = req1_a;
          b_d      = req1_b;
          funct3_d = req1_funct3;
          owner_d  = 1'b1;
          rr_ptr_d = 1'b0;
          state_d  = CMP;
        end
      end
      CMP: begin
        result_d  = dec_result;
        illegal_d = dec_illegal;
        state_d   = RESP;
      end
      RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rsp0_valid_d = (state_d == RESP) && !owner_d;
    rsp1_valid_d = (state_d == RESP) &&  owner_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 1'b0;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      funct3_q     <= 3'b000;
      result_q     <= 1'b0;
      illegal_q    <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      funct3_q     <= funct3_d;
      result_q     <= result_d;
      illegal_q    <= illegal_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign cmp_operand1 = a_q;
  assign cmp_operand2 = b_q;
  assign cmp_BrUn     = funct3_q[2] & funct3_q[1];
  assign rsp0_valid   = rsp0_valid_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign rsp_result   = result_q;
  assign rsp_illegal  = illegal_q;

endmodule

// File: doc/branch_cmp_arbiter.md
Name: branch_cmp_arbiter

Overview:
- Shares one branch comparator (operand1/operand2/BrUn in, BrEq/BrLT out) between two requesters: requester 0 is branch resolution, requester 1 is the ALU set-less-than path.
- Arbitrates round-robin, latches the winning operands and drives them to the comparator.
- Samples BrEq/BrLT and decodes them per funct3 into a 1-bit result.
- Returns the result on a per-requester valid/ready response channel.
- Sits between decode/execute and the comparator in the multi-cycle core variant.

Parameters:
- XLEN, 32, operand width.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- req0_valid  input  1  requester 0 has a comparison
- req0_ready  output  1  requester 0 accepted this cycle
- req0_a  input  XLEN  requester 0 first operand
- req0_b  input  XLEN  requester 0 second operand
- req0_funct3  input  3  requester 0 RISC-V branch funct3
- req1_valid  input  1  requester 1 has a comparison
- req1_ready  output  1  requester 1 accepted this cycle
- req1_a  input  XLEN  requester 1 first operand
- req1_b  input  XLEN  requester 1 second operand
- req1_funct3  input  3  requester 1 funct3 (branch encoding)
- cmp_operand1  output  XLEN  to comparator operand1
- cmp_operand2  output  XLEN  to comparator operand2
- cmp_BrUn  output  1  to comparator BrUn (1 = unsigned)
- cmp_BrEq  input  1  from comparator
- cmp_BrLT  input  1  from comparator
- rsp0_valid  output  1  result for requester 0 valid
- rsp0_ready  input  1  requester 0 consumes result
- rsp1_valid  output  1  result for requester 1 valid
- rsp1_ready  input  1  requester 1 consumes result
- rsp_result  output  1  comparison outcome (1 = taken/true)
- rsp_illegal  output  1  funct3 was 010 or 011

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled at the rising edge.
- Reset values:
  - State = IDLE, rr_ptr = 0.
  - Latched operands = 0, so cmp_operand1 = cmp_operand2 = 0 and cmp_BrUn = 0.
  - All ready and valid outputs 0; rsp_result = 0; rsp_illegal = 0.
- Reset mid-operation aborts the transaction. No response is emitted for it.
- FSM states: IDLE, CMP, RESP.
- IDLE:
  - reqX_ready = 1 combinationally only for the requester granted this cycle; the other requester's ready stays 0.
  - Grant rules:
    - Only one valid: it wins.
    - Both valid: the requester equal to rr_ptr wins.
  - On handshake (valid && ready):
    - latch a, b, funct3 and owner id;
    - set rr_ptr = ~owner;
    - go to CMP.
- CMP (exactly 1 cycle):
  - cmp_operand1/2 = latched a/b. cmp_BrUn = funct3[1] & funct3[2], i.e. 1 for 110/111.
  - At the clock edge, register the result and illegal flag, then go to RESP.
  - funct3 decode for the result:
    - 000: BrEq
    - 001: ~BrEq
    - 100 / 110: BrLT
    - 101 / 111: ~BrLT
    - 010 / 011: result 0, illegal 1
- RESP:
  - rsp<owner>_valid = 1; the other rsp_valid = 0.
  - rsp_result and rsp_illegal stay stable while valid.
  - On rsp<owner>_ready = 1: go to IDLE. Hold indefinitely while ready = 0.
- Comparator outputs hold the latched values in every state; they change only on a new accept.
- Latency: accept at edge N → rsp_valid high during cycle N+2.
- Throughput: at most one transaction per 3 cycles when rsp_ready is tied high.
- No new request is accepted in CMP or RESP; both req_ready are 0 there.
- Requests may change or deassert while not accepted (no protocol requirement on requesters); only accepted values matter.
- rr_ptr updates only on accept, giving strict alternation under continuous contention.

Test Plan:
- Reset with both reqs valid → all ready/valid 0, cmp outputs 0. After reset release: req0 granted (rr_ptr = 0) and req0_ready = 1 in the first cycle.
- req0 a=5, b=5, funct3=000 (comparator model BrEq=1) → cmp_BrUn=0; rsp0_valid at N+2 with result=1. funct3=001 with the same operands → result=0.
- req1 a=0xFFFFFFFF, b=1, funct3=100 → cmp_BrUn=0, result=1. funct3=110 → cmp_BrUn=1, result=0. funct3=111 → result=1.
- Both valid continuously for 4 transactions, rsp_ready=1 → grant order 0,1,0,1, each rsp on the matching channel, accepts spaced 3 cycles apart.
- req0 funct3=010 → rsp_illegal=1, result=0. Hold rsp0_ready=0 for 5 cycles → rsp0_valid and result stable, req1_ready stays 0 despite req1_valid.
- rst_n low during CMP → next cycle state IDLE, no rsp_valid, rr_ptr=0.
